// File: rtl/cart_bus_master.sv
// rtl/cart_bus_master.sv - console-side PRG/CHR cartridge bus initiator with CIRAM routing
// Two independent req/ack channels, each IDLE -> DRIVE -> WAIT -> DONE, bus outputs registered.
module cart_bus_master #(
    parameter int PRG_LAT = 1,
    parameter int CHR_LAT = 1
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        prg_req,
    input  logic        prg_we,
    input  logic [14:0] prg_addr,
    input  logic [7:0]  prg_wdata,
    output logic        prg_ack,
    output logic [7:0]  prg_rdata,
    input  logic        chr_req,
    input  logic        chr_we,
    input  logic [13:0] chr_addr,
    input  logic [7:0]  chr_wdata,
    output logic        chr_ack,
    output logic [7:0]  chr_rdata,
    output logic        cart_prg_nce,
    output logic [14:0] cart_prg_a,
    output logic        cart_prg_r_nw,
    output logic [7:0]  cart_prg_dout,
    input  logic [7:0]  cart_prg_din,
    output logic [13:0] cart_chr_a,
    output logic        cart_chr_r_nw,
    output logic [7:0]  cart_chr_dout,
    input  logic [7:0]  cart_chr_din,
    input  logic        cart_ciram_nce,
    input  logic        cart_ciram_a10,
    output logic [10:0] ciram_a,
    output logic        ciram_we,
    output logic [7:0]  ciram_dout,
    input  logic [7:0]  ciram_din
);
    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, DONE} state_t;

    localparam logic [1:0] PRG_LAST = 2'(PRG_LAT - 1);
    localparam logic [1:0] CHR_LAST = 2'(CHR_LAT - 1);

    state_t      prg_state_q;
    logic [1:0]  prg_cnt_q;
    logic [14:0] prg_addr_q;
    logic        prg_we_q;
    logic [7:0]  prg_wdata_q;
    logic [7:0]  prg_rdata_q;
    logic        prg_nce_q;
    logic        prg_rnw_q;
    logic        prg_ack_q;

    state_t      chr_state_q;
    logic [1:0]  chr_cnt_q;
    logic [13:0] chr_addr_q;
    logic        chr_we_q;
    logic [7:0]  chr_wdata_q;
    logic [7:0]  chr_rdata_q;
    logic        chr_rnw_q;
    logic        chr_ack_q;
    logic [7:0]  chr_din_sel;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prg_state_q <= IDLE;
            prg_cnt_q   <= 2'd0;
            prg_addr_q  <= 15'd0;
            prg_we_q    <= 1'b0;
            prg_wdata_q <= 8'd0;
            prg_rdata_q <= 8'd0;
            prg_nce_q   <= 1'b1;
            prg_rnw_q   <= 1'b1;
            prg_ack_q   <= 1'b0;
        end else begin
            case (prg_state_q)
                IDLE: begin
                    if (prg_req) begin
                        prg_addr_q  <= prg_addr;
                        prg_we_q    <= prg_we;
                        prg_wdata_q <= prg_wdata;
                        prg_nce_q   <= 1'b0;
                        prg_rnw_q   <= ~prg_we;
                        prg_state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The write strobe is dropped after one cycle so edge-sampled mapper registers see one write.
                    prg_rnw_q <= 1'b1;
                    prg_cnt_q <= 2'd1;
                    if (PRG_LAT == 1) begin
                        prg_ack_q   <= 1'b1;
                        prg_state_q <= DONE;
                    end else begin
                        prg_state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (prg_cnt_q == PRG_LAST) begin
                        prg_ack_q   <= 1'b1;
                        prg_state_q <= DONE;
                    end else begin
                        prg_cnt_q <= prg_cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    prg_ack_q <= 1'b0;
                    prg_nce_q <= 1'b1;
                    if (!prg_we_q) prg_rdata_q <= cart_prg_din;
                    prg_state_q <= IDLE;
                end
                default: prg_state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            chr_state_q <= IDLE;
            chr_cnt_q   <= 2'd0;
            chr_addr_q  <= 14'd0;
            chr_we_q    <= 1'b0;
            chr_wdata_q <= 8'd0;
            chr_rdata_q <= 8'd0;
            chr_rnw_q   <= 1'b1;
            chr_ack_q   <= 1'b0;
        end else begin
            case (chr_state_q)
                IDLE: begin
                    if (chr_req) begin
                        chr_addr_q  <= chr_addr;
                        chr_we_q    <= chr_we;
                        chr_wdata_q <= chr_wdata;
                        chr_rnw_q   <= ~chr_we;
                        chr_state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    chr_rnw_q <= 1'b1;
                    chr_cnt_q <= 2'd1;
                    if (CHR_LAT == 1) begin
                        chr_ack_q   <= 1'b1;
                        chr_state_q <= DONE;
                    end else begin
                        chr_state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (chr_cnt_q == CHR_LAST) begin
                        chr_ack_q   <= 1'b1;
                        chr_state_q <= DONE;
                    end else begin
                        chr_cnt_q <= chr_cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    chr_ack_q <= 1'b0;
                    if (!chr_we_q) chr_rdata_q <= chr_din_sel;
                    chr_state_q <= IDLE;
                end
                default: chr_state_q <= IDLE;
            endcase
        end
    end

    // Cart read data only becomes valid inside DONE, so the ack cycle forwards it directly.
    assign chr_din_sel   = cart_ciram_nce ? cart_chr_din : ciram_din;
    assign prg_rdata     = (prg_state_q == DONE && !prg_we_q) ? cart_prg_din : prg_rdata_q;
    assign chr_rdata     = (chr_state_q == DONE && !chr_we_q) ? chr_din_sel : chr_rdata_q;
    assign prg_ack       = prg_ack_q;
    assign chr_ack       = chr_ack_q;

    assign cart_prg_nce  = prg_nce_q;
    assign cart_prg_a    = prg_addr_q;
    assign cart_prg_r_nw = prg_rnw_q;
    assign cart_prg_dout = prg_wdata_q;

    assign cart_chr_a    = chr_addr_q;
    assign cart_chr_r_nw = chr_rnw_q;
    assign cart_chr_dout = chr_wdata_q;

    // The cart decodes ciram_nce/a10 from the address it is being driven, so the strobe follows combinationally.
    assign ciram_a    = {cart_ciram_a10, chr_addr_q[9:0]};
    assign ciram_we   = (chr_state_q == DRIVE) & chr_we_q & ~cart_ciram_nce;
    assign ciram_dout = chr_wdata_q;
endmodule

// File: tb/tb_cart_bus_master.sv
// tb/tb_cart_bus_master.sv - scoreboard bench for cart_bus_master with UNROM-style cart and CIRAM models
module tb_cart_bus_master;
    localparam int PRG_LAT = 2;
    localparam int CHR_LAT = 1;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        prg_req = 1'b0, prg_we = 1'b0;
    logic [14:0] prg_addr = '0;
    logic [7:0]  prg_wdata = '0;
    logic        prg_ack;
    logic [7:0]  prg_rdata;
    logic        chr_req = 1'b0, chr_we = 1'b0;
    logic [13:0] chr_addr = '0;
    logic [7:0]  chr_wdata = '0;
    logic        chr_ack;
    logic [7:0]  chr_rdata;
    logic        cart_prg_nce, cart_prg_r_nw;
    logic [14:0] cart_prg_a;
    logic [7:0]  cart_prg_dout, cart_prg_din;
    logic [13:0] cart_chr_a;
    logic        cart_chr_r_nw;
    logic [7:0]  cart_chr_dout, cart_chr_din;
    logic        cart_ciram_nce, cart_ciram_a10;
    logic [10:0] ciram_a;
    logic        ciram_we;
    logic [7:0]  ciram_dout, ciram_din;

    cart_bus_master #(.PRG_LAT(PRG_LAT), .CHR_LAT(CHR_LAT)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
        .prg_ack(prg_ack), .prg_rdata(prg_rdata),
        .chr_req(chr_req), .chr_we(chr_we), .chr_addr(chr_addr), .chr_wdata(chr_wdata),
        .chr_ack(chr_ack), .chr_rdata(chr_rdata),
        .cart_prg_nce(cart_prg_nce), .cart_prg_a(cart_prg_a), .cart_prg_r_nw(cart_prg_r_nw),
        .cart_prg_dout(cart_prg_dout), .cart_prg_din(cart_prg_din),
        .cart_chr_a(cart_chr_a), .cart_chr_r_nw(cart_chr_r_nw), .cart_chr_dout(cart_chr_dout),
        .cart_chr_din(cart_chr_din), .cart_ciram_nce(cart_ciram_nce), .cart_ciram_a10(cart_ciram_a10),
        .ciram_a(ciram_a), .ciram_we(ciram_we), .ciram_dout(ciram_dout), .ciram_din(ciram_din)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cartridge: UNROM-like PRG (16K switchable at $0000, last bank fixed at $4000), 8K CHR-RAM, vertical mirroring
    logic [7:0] prg_rom [0:131071];
    logic [7:0] chr_ram [0:8191];
    logic [7:0] ciram   [0:2047];
    logic [2:0] cart_bank = 3'd0;
    logic [7:0] prg_pipe [0:PRG_LAT-1];
    logic [7:0] chr_pipe [0:CHR_LAT-1];
    logic [7:0] nt_pipe  [0:CHR_LAT-1];
    logic count_en = 1'b0;
    int prg_nce_cycles = 0, prg_strobes = 0, chr_strobes = 0, ciram_wes = 0;

    assign cart_ciram_nce = ~cart_chr_a[13];
    assign cart_ciram_a10 = cart_chr_a[10];
    assign cart_prg_din   = prg_pipe[PRG_LAT-1];
    assign cart_chr_din   = chr_pipe[CHR_LAT-1];
    assign ciram_din      = nt_pipe[CHR_LAT-1];

    always @(posedge clk_sys) begin
        prg_pipe[0] <= prg_rom[{cart_prg_a[14] ? 3'd7 : cart_bank, cart_prg_a[13:0]}];
        for (int i = 1; i < PRG_LAT; i++) prg_pipe[i] <= prg_pipe[i-1];
        chr_pipe[0] <= cart_chr_a[13] ? 8'($urandom) : chr_ram[cart_chr_a[12:0]];
        nt_pipe[0]  <= ciram[ciram_a];
        for (int i = 1; i < CHR_LAT; i++) begin
            chr_pipe[i] <= chr_pipe[i-1];
            nt_pipe[i]  <= nt_pipe[i-1];
        end
        if (!cart_prg_nce && !cart_prg_r_nw) cart_bank <= cart_prg_dout[2:0];
        if (!cart_chr_r_nw && !cart_chr_a[13]) chr_ram[cart_chr_a[12:0]] <= cart_chr_dout;
        if (ciram_we) ciram[ciram_a] <= ciram_dout;
        if (count_en) begin
            if (!cart_prg_nce) prg_nce_cycles <= prg_nce_cycles + 1;
            if (!cart_prg_nce && !cart_prg_r_nw) prg_strobes <= prg_strobes + 1;
            if (!cart_chr_r_nw) chr_strobes <= chr_strobes + 1;
            if (ciram_we) ciram_wes <= ciram_wes + 1;
        end
    end

    // Reference model: console-visible memory map and channel occupancy
    typedef struct { int cyc; logic [7:0] data; } exp_t;
    exp_t prg_q[$], chr_q[$];
    logic [7:0] ref_chr [0:8191];
    logic [7:0] ref_nt  [0:2047];
    int ref_bank = 0, prg_free = 0, chr_free = 0;
    logic [7:0] ref_prg_last = 8'd0, ref_chr_last = 8'd0;
    int prg_txns = 0, prg_wr = 0, chr_txns = 0, chr_wr = 0, nt_wr = 0;

    task automatic prg_txn(input logic we, input logic [14:0] a, input logic [7:0] d);
        exp_t e;
        int acc, n;
        prg_req = 1'b1; prg_we = we; prg_addr = a; prg_wdata = d;
        acc = (cyc + 1 > prg_free) ? cyc + 1 : prg_free;
        e.cyc = acc + PRG_LAT;
        prg_free = e.cyc + 2;
        if (we) ref_bank = int'(d) % 8;
        else ref_prg_last = prg_rom[((a >= 15'h4000) ? 7 : ref_bank) * 16384 + int'(a) % 16384];
        e.data = ref_prg_last;
        prg_q.push_back(e);
        prg_txns++;
        if (we) prg_wr++;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!prg_ack && n < 40);
        if (!prg_ack) begin
            checks++; errors++;
            $display("FAIL prg_ack_timeout: no ack within 40 cycles for addr %0h", a);
        end
    endtask

    task automatic chr_txn(input logic we, input logic [13:0] a, input logic [7:0] d);
        exp_t e;
        int acc, n;
        chr_req = 1'b1; chr_we = we; chr_addr = a; chr_wdata = d;
        acc = (cyc + 1 > chr_free) ? cyc + 1 : chr_free;
        e.cyc = acc + CHR_LAT;
        chr_free = e.cyc + 2;
        if (a >= 14'h2000) begin
            if (we) begin ref_nt[int'(a) % 2048] = d; nt_wr++; end
            else ref_chr_last = ref_nt[int'(a) % 2048];
        end else begin
            if (we) ref_chr[int'(a) % 8192] = d;
            else ref_chr_last = ref_chr[int'(a) % 8192];
        end
        e.data = ref_chr_last;
        chr_q.push_back(e);
        chr_txns++;
        if (we) chr_wr++;
        n = 0;
        do begin @(negedge clk_sys); n++; end while (!chr_ack && n < 40);
        if (!chr_ack) begin
            checks++; errors++;
            $display("FAIL chr_ack_timeout: no ack within 40 cycles for addr %0h", a);
        end
    endtask

    task automatic prg_idle(input int n);
        prg_req = 1'b0;
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chr_idle(input int n);
        chr_req = 1'b0;
        repeat (n) @(negedge clk_sys);
    endtask

    exp_t pe, ce;
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (prg_ack) begin
                if (prg_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL prg_unexpected_ack at cycle %0d", cyc);
                end else begin
                    pe = prg_q.pop_front();
                    check("prg_ack_cycle", cyc, pe.cyc);
                    check("prg_rdata", {24'd0, prg_rdata}, {24'd0, pe.data});
                end
            end
            if (chr_ack) begin
                if (chr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL chr_unexpected_ack at cycle %0d", cyc);
                end else begin
                    ce = chr_q.pop_front();
                    check("chr_ack_cycle", cyc, ce.cyc);
                    check("chr_rdata", {24'd0, chr_rdata}, {24'd0, ce.data});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 131072; i++) prg_rom[i] = 8'($urandom);
        for (int i = 0; i < 8192; i++) begin chr_ram[i] = 8'($urandom); ref_chr[i] = chr_ram[i]; end
        for (int i = 0; i < 2048; i++) begin ciram[i] = 8'($urandom); ref_nt[i] = ciram[i]; end
        for (int i = 0; i < PRG_LAT; i++) prg_pipe[i] = 8'd0;
        for (int i = 0; i < CHR_LAT; i++) begin chr_pipe[i] = 8'd0; nt_pipe[i] = 8'd0; end
        prg_rom[7*16384 + 'h0123] = 8'hA5;
        ciram['h405] = 8'h3C;
        ref_nt['h405] = 8'h3C;

        repeat (2) @(negedge clk_sys);
        check("rst_prg_nce", cart_prg_nce, 1);
        check("rst_prg_r_nw", cart_prg_r_nw, 1);
        check("rst_chr_r_nw", cart_chr_r_nw, 1);
        check("rst_ciram_we", ciram_we, 0);
        check("rst_acks", {prg_ack, chr_ack}, 0);
        check("rst_rdata", {prg_rdata, chr_rdata}, 0);
        check("rst_prg_a", cart_prg_a, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);

        prg_req = 1'b1; prg_we = 1'b1; prg_addr = 15'h0000; prg_wdata = 8'h05;
        @(negedge clk_sys);
        check("drive_prg_nce", cart_prg_nce, 0);
        check("drive_prg_r_nw", cart_prg_r_nw, 0);
        prg_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_prg_nce", cart_prg_nce, 1);
        check("midrst_prg_r_nw", cart_prg_r_nw, 1);
        check("midrst_prg_ack", prg_ack, 0);
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        check("midrst_rdata", {prg_rdata, chr_rdata}, 0);
        count_en = 1'b1;
        @(negedge clk_sys);

        prg_txn(1'b0, 15'h4123, 8'h00); prg_idle(2);
        prg_txn(1'b1, 15'h0000, 8'h03); prg_idle(1);
        prg_txn(1'b0, 15'h0010, 8'h00); prg_idle(1);
        chr_txn(1'b0, 14'h2405, 8'h00);
        check("ciram_a_2405", ciram_a, 11'h405);
        chr_idle(1);
        chr_txn(1'b1, 14'h1FFF, 8'h5A); chr_idle(1);
        chr_txn(1'b0, 14'h1FFF, 8'h00); chr_idle(2);

        fork
            begin repeat (3) prg_txn(1'b0, 15'($urandom), 8'h00); prg_idle(1); end
            begin repeat (3) chr_txn(1'b0, 14'($urandom), 8'h00); chr_idle(1); end
        join

        fork
            begin
                for (int b = 0; b < 40; b++) begin
                    repeat ($urandom_range(1, 4))
                        prg_txn($urandom_range(0, 3) == 0, 15'($urandom), 8'($urandom));
                    prg_idle($urandom_range(0, 3));
                end
            end
            begin
                for (int b = 0; b < 40; b++) begin
                    repeat ($urandom_range(1, 4))
                        chr_txn($urandom_range(0, 2) == 0, 14'($urandom), 8'($urandom));
                    chr_idle($urandom_range(0, 3));
                end
            end
        join

        repeat (10) @(negedge clk_sys);
        check("prg_queue_drained", prg_q.size(), 0);
        check("chr_queue_drained", chr_q.size(), 0);
        check("prg_nce_low_cycles", prg_nce_cycles, prg_txns * (PRG_LAT + 1));
        check("prg_write_strobes", prg_strobes, prg_wr);
        check("chr_write_strobes", chr_strobes, chr_wr);
        check("ciram_write_strobes", ciram_wes, nt_wr);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
